// File: rtl/cwgan_train_scheduler_if.sv
// Control/status bundle between the host, the training scheduler and the
// CWGAN-GP core start/mode/busy/done pins.
interface cwgan_train_scheduler_if #(
  parameter int STEP_W = 16,
  parameter int CRIT_W = 4
);
  logic              cmd_start;
  logic              cmd_abort;
  logic [STEP_W-1:0] cfg_num_steps;
  logic [CRIT_W-1:0] cfg_n_critic;
  logic              core_start;
  logic              core_mode;
  logic              core_busy;
  logic              core_done;
  logic              sched_busy;
  logic              sched_done;
  logic              sched_error;
  logic [STEP_W-1:0] step_count;
  logic [CRIT_W-1:0] critic_count;

  // Master is the surrounding environment (host registers plus core pins).
  modport master (
    output cmd_start, cmd_abort, cfg_num_steps, cfg_n_critic, core_busy, core_done,
    input  core_start, core_mode, sched_busy, sched_done, sched_error,
           step_count, critic_count
  );

  modport slave (
    input  cmd_start, cmd_abort, cfg_num_steps, cfg_n_critic, core_busy, core_done,
    output core_start, core_mode, sched_busy, sched_done, sched_error,
           step_count, critic_count
  );
endinterface

// File: rtl/cwgan_train_scheduler.sv
// WGAN-GP training sequencer: n_critic critic passes then one generator pass
// per step, with a per-pass timeout watchdog on the core handshake.
module cwgan_train_scheduler #(
  parameter int STEP_W         = 16,
  parameter int CRIT_W         = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TMR_W          = 17
) (
  input  logic                          clk,
  input  logic                          rst,
  cwgan_train_scheduler_if.slave        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [TMR_W-1:0] LP_TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic [STEP_W-1:0] r_numSteps;
  logic [CRIT_W-1:0] r_nCritic;
  logic [STEP_W-1:0] r_stepCount;
  logic [CRIT_W-1:0] r_criticCount;
  logic [TMR_W-1:0]  r_timer;
  logic              r_coreStart;
  logic              r_coreMode;
  logic              r_schedBusy;
  logic              r_schedDone;
  logic              r_schedError;

  logic [TMR_W-1:0]  w_timerNext;
  logic [CRIT_W-1:0] w_criticNext;
  logic              w_abort;
  logic              w_unusedCoreBusy;

  assign w_timerNext      = r_timer + 1'b1;
  assign w_criticNext     = r_criticCount + 1'b1;
  assign w_unusedCoreBusy = bus.core_busy;
  assign w_abort          = bus.cmd_abort &&
                            (r_state == S_ISSUE || r_state == S_WAIT ||
                             r_state == S_GAP   || r_state == S_ERROR);

  // Abort outranks core_done and the watchdog; core_done outranks the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_numSteps    <= '0;
      r_nCritic     <= '0;
      r_stepCount   <= '0;
      r_criticCount <= '0;
      r_timer       <= '0;
      r_coreStart   <= 1'b0;
      r_coreMode    <= 1'b0;
      r_schedBusy   <= 1'b0;
      r_schedDone   <= 1'b0;
      r_schedError  <= 1'b0;
    end else if (w_abort) begin
      r_state      <= S_IDLE;
      r_coreStart  <= 1'b0;
      r_schedDone  <= 1'b0;
      r_schedBusy  <= 1'b0;
      r_schedError <= 1'b0;
    end else begin
      r_coreStart <= 1'b0;
      r_schedDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_start) begin
            r_numSteps    <= bus.cfg_num_steps;
            r_nCritic     <= bus.cfg_n_critic;
            r_stepCount   <= '0;
            r_criticCount <= '0;
            r_schedError  <= 1'b0;
            r_coreMode    <= (bus.cfg_n_critic != '0);
            if (bus.cfg_num_steps == '0) begin
              r_state     <= S_DONE;
              r_schedDone <= 1'b1;
            end else begin
              r_state     <= S_ISSUE;
              r_coreStart <= 1'b1;
              r_schedBusy <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= w_timerNext;
          if (bus.core_done) begin
            r_state <= S_GAP;
            if (r_coreMode) begin
              r_criticCount <= w_criticNext;
              if (w_criticNext == r_nCritic) begin
                r_coreMode <= 1'b0;
              end
            end else begin
              r_stepCount   <= r_stepCount + 1'b1;
              r_criticCount <= '0;
              r_coreMode    <= (r_nCritic != '0);
            end
          end else if (w_timerNext == LP_TIMER_LAST) begin
            r_state      <= S_ERROR;
            r_schedBusy  <= 1'b0;
            r_schedError <= 1'b1;
          end
        end
        S_GAP: begin
          if (r_stepCount == r_numSteps) begin
            r_state     <= S_DONE;
            r_schedDone <= 1'b1;
            r_schedBusy <= 1'b0;
          end else begin
            r_state     <= S_ISSUE;
            r_coreStart <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_ERROR: begin
          r_state <= S_ERROR;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.core_start   = r_coreStart;
  assign bus.core_mode    = r_coreMode;
  assign bus.sched_busy   = r_schedBusy;
  assign bus.sched_done   = r_schedDone;
  assign bus.sched_error  = r_schedError;
  assign bus.step_count   = r_stepCount;
  assign bus.critic_count = r_criticCount;

endmodule

// File: tb/tb_cwgan_train_scheduler.sv
// Directed bench for cwgan_train_scheduler with a delayed-done core model.
module tb_cwgan_train_scheduler;
  localparam int STEP_W  = 16;
  localparam int CRIT_W  = 4;
  localparam int TIMEOUT = 50;
  localparam int DELAY   = 20;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   errors   = 0;
  int   startCnt = 0;
  int   doneCnt  = 0;
  int   busyCnt  = 0;
  logic modeLog[$];
  logic respEn   = 1'b0;
  int   respCnt  = 0;
  logic respDone = 1'b0;
  logic manDone  = 1'b0;

  cwgan_train_scheduler_if #(.STEP_W(STEP_W), .CRIT_W(CRIT_W)) bus ();

  cwgan_train_scheduler #(
    .STEP_W(STEP_W), .CRIT_W(CRIT_W), .TIMEOUT_CYCLES(TIMEOUT), .TMR_W(17)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.core_done = respDone | manDone;
  assign bus.core_busy = (respCnt > 0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core model: pulses done DELAY cycles after each start while enabled.
  always @(negedge clk) begin
    respDone = 1'b0;
    if (!respEn) respCnt = 0;
    else if (respCnt > 0) begin
      respCnt = respCnt - 1;
      if (respCnt == 0) respDone = 1'b1;
    end else if (bus.core_start === 1'b1) respCnt = DELAY;
  end

  // Passive monitor sampling one time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.core_start === 1'b1) begin
      startCnt++;
      modeLog.push_back(bus.core_mode);
    end
    if (bus.sched_done === 1'b1) doneCnt++;
    if (bus.sched_busy === 1'b1) busyCnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseStart(input int num, input int nc);
    bus.cfg_num_steps = STEP_W'(num);
    bus.cfg_n_critic  = CRIT_W'(nc);
    bus.cmd_start     = 1'b1;
    @(negedge clk);
    bus.cmd_start     = 1'b0;
  endtask

  task automatic pulseAbort();
    bus.cmd_abort = 1'b1;
    @(negedge clk);
    bus.cmd_abort = 1'b0;
  endtask

  task automatic pulseDone();
    manDone = 1'b1;
    @(negedge clk);
    manDone = 1'b0;
  endtask

  task automatic waitStart(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (bus.core_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitDone(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (bus.sched_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1);
    checks++; if ({bus.core_start, bus.core_mode, bus.sched_busy, bus.sched_done, bus.sched_error} !== 5'b0) begin errors++; $display("[TB] FAIL reset_flags got %b expected 00000", {bus.core_start, bus.core_mode, bus.sched_busy, bus.sched_done, bus.sched_error}); end
    checks++; if (bus.step_count !== '0) begin errors++; $display("[TB] FAIL reset_step got %0d expected 0", bus.step_count); end
    checks++; if (bus.critic_count !== '0) begin errors++; $display("[TB] FAIL reset_critic got %0d expected 0", bus.critic_count); end
    rst = 1'b0;
    cyc(2);
    checks++; if (bus.sched_busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b expected 0", bus.sched_busy); end
  endtask

  task automatic test_critic_schedule();
    int s0, q0, d0;
    bit ok;
    logic expMode;
    s0 = startCnt; q0 = modeLog.size(); d0 = doneCnt;
    respEn = 1'b1;
    pulseStart(2, 5);
    waitDone(1000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL crit_done_timeout got 0 expected 1"); end
    cyc(3);
    respEn = 1'b0;
    checks++; if (startCnt - s0 != 12) begin errors++; $display("[TB] FAIL crit_starts got %0d expected 12", startCnt - s0); end
    for (int i = 0; i < 12; i++) begin
      expMode = ((i % 6) != 5);
      checks++;
      if (q0 + i >= modeLog.size()) begin errors++; $display("[TB] FAIL crit_mode[%0d] got none expected %b", i, expMode); end
      else if (modeLog[q0 + i] !== expMode) begin errors++; $display("[TB] FAIL crit_mode[%0d] got %b expected %b", i, modeLog[q0 + i], expMode); end
    end
    checks++; if (doneCnt - d0 != 1) begin errors++; $display("[TB] FAIL crit_sched_done got %0d expected 1", doneCnt - d0); end
    checks++; if (bus.step_count !== 16'd2) begin errors++; $display("[TB] FAIL crit_step got %0d expected 2", bus.step_count); end
    checks++; if (bus.critic_count !== 4'd0) begin errors++; $display("[TB] FAIL crit_critic got %0d expected 0", bus.critic_count); end
  endtask

  task automatic test_no_critic();
    int s0, q0, d0;
    bit ok;
    s0 = startCnt; q0 = modeLog.size(); d0 = doneCnt;
    respEn = 1'b1;
    pulseStart(3, 0);
    waitDone(500, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL nocrit_done_timeout got 0 expected 1"); end
    cyc(3);
    respEn = 1'b0;
    checks++; if (startCnt - s0 != 3) begin errors++; $display("[TB] FAIL nocrit_starts got %0d expected 3", startCnt - s0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q0 + i >= modeLog.size()) begin errors++; $display("[TB] FAIL nocrit_mode[%0d] got none expected 0", i); end
      else if (modeLog[q0 + i] !== 1'b0) begin errors++; $display("[TB] FAIL nocrit_mode[%0d] got %b expected 0", i, modeLog[q0 + i]); end
    end
    checks++; if (doneCnt - d0 != 1) begin errors++; $display("[TB] FAIL nocrit_sched_done got %0d expected 1", doneCnt - d0); end
    checks++; if (bus.step_count !== 16'd3) begin errors++; $display("[TB] FAIL nocrit_step got %0d expected 3", bus.step_count); end
  endtask

  task automatic test_zero_steps();
    int s0, b0;
    s0 = startCnt; b0 = busyCnt;
    pulseStart(0, 3);
    checks++; if (bus.sched_done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done got %b expected 1", bus.sched_done); end
    checks++; if (bus.step_count !== 16'd0) begin errors++; $display("[TB] FAIL zero_step_clear got %0d expected 0", bus.step_count); end
    cyc(1);
    checks++; if (bus.sched_done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_width got %b expected 0", bus.sched_done); end
    cyc(3);
    checks++; if (startCnt - s0 != 0) begin errors++; $display("[TB] FAIL zero_starts got %0d expected 0", startCnt - s0); end
    checks++; if (busyCnt - b0 != 0) begin errors++; $display("[TB] FAIL zero_busy got %0d expected 0", busyCnt - b0); end
  endtask

  task automatic test_latency();
    bit ok;
    pulseStart(1, 1);
    waitStart(10, ok);
    checks++; if (!ok || bus.core_mode !== 1'b1) begin errors++; $display("[TB] FAIL lat_first_start got ok=%0d mode=%b expected ok=1 mode=1", ok, bus.core_mode); end
    cyc(3);
    pulseDone();
    checks++; if (bus.core_start !== 1'b0 || bus.sched_busy !== 1'b1) begin errors++; $display("[TB] FAIL lat_gap got start=%b busy=%b expected start=0 busy=1", bus.core_start, bus.sched_busy); end
    checks++; if (bus.critic_count !== 4'd1 || bus.core_mode !== 1'b0) begin errors++; $display("[TB] FAIL lat_crit got count=%0d mode=%b expected count=1 mode=0", bus.critic_count, bus.core_mode); end
    cyc(1);
    checks++; if (bus.core_start !== 1'b1) begin errors++; $display("[TB] FAIL lat_restart got %b expected 1", bus.core_start); end
    cyc(2);
    pulseDone();
    checks++; if (bus.sched_done !== 1'b0 || bus.step_count !== 16'd1) begin errors++; $display("[TB] FAIL lat_gen got done=%b step=%0d expected done=0 step=1", bus.sched_done, bus.step_count); end
    cyc(1);
    checks++; if (bus.sched_done !== 1'b1 || bus.sched_busy !== 1'b0) begin errors++; $display("[TB] FAIL lat_sched_done got done=%b busy=%b expected done=1 busy=0", bus.sched_done, bus.sched_busy); end
    cyc(1);
    checks++; if (bus.sched_done !== 1'b0) begin errors++; $display("[TB] FAIL lat_done_width got %b expected 0", bus.sched_done); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    pulseStart(2, 1);
    waitStart(10, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_first_start got 0 expected 1"); end
    cyc(2);
    bus.cfg_num_steps = 16'd7;
    bus.cfg_n_critic  = 4'd3;
    bus.cmd_start     = 1'b1;
    @(negedge clk);
    bus.cmd_start     = 1'b0;
    pulseDone();
    manDone = 1'b1;
    @(negedge clk);
    manDone = 1'b0;
    checks++; if (bus.core_start !== 1'b1 || bus.critic_count !== 4'd1 || bus.core_mode !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap_done got start=%b crit=%0d mode=%b expected start=1 crit=1 mode=0", bus.core_start, bus.critic_count, bus.core_mode); end
    cyc(2);
    pulseDone();
    checks++; if (bus.step_count !== 16'd1 || bus.critic_count !== 4'd0 || bus.core_mode !== 1'b1) begin errors++; $display("[TB] FAIL b2b_step1 got step=%0d crit=%0d mode=%b expected step=1 crit=0 mode=1", bus.step_count, bus.critic_count, bus.core_mode); end
    cyc(3);
    pulseDone();
    cyc(3);
    pulseDone();
    cyc(1);
    checks++; if (bus.sched_done !== 1'b1 || bus.step_count !== 16'd2) begin errors++; $display("[TB] FAIL b2b_end got done=%b step=%0d expected done=1 step=2", bus.sched_done, bus.step_count); end
  endtask

  task automatic test_abort();
    int s0, d0;
    bit ok;
    s0 = startCnt; d0 = doneCnt;
    respEn = 1'b1;
    pulseStart(1, 5);
    for (int k = 0; k < 3; k++) begin
      waitStart(100, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL abort_wait_start%0d got 0 expected 1", k); end
      if (k < 2) cyc(1);
    end
    cyc(5);
    pulseAbort();
    checks++; if (bus.sched_busy !== 1'b0 || bus.core_start !== 1'b0 || bus.sched_error !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle got busy=%b start=%b err=%b expected 0 0 0", bus.sched_busy, bus.core_start, bus.sched_error); end
    checks++; if (bus.critic_count !== 4'd2) begin errors++; $display("[TB] FAIL abort_critic got %0d expected 2", bus.critic_count); end
    cyc(40);
    respEn = 1'b0;
    checks++; if (startCnt - s0 != 3) begin errors++; $display("[TB] FAIL abort_starts got %0d expected 3", startCnt - s0); end
    checks++; if (doneCnt - d0 != 0) begin errors++; $display("[TB] FAIL abort_sched_done got %0d expected 0", doneCnt - d0); end
    checks++; if (bus.critic_count !== 4'd2) begin errors++; $display("[TB] FAIL abort_late_done got %0d expected 2", bus.critic_count); end
  endtask

  task automatic test_timeout();
    int d0;
    bit ok;
    pulseStart(1, 2);
    waitStart(10, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL to_start got 0 expected 1"); end
    cyc(TIMEOUT - 1);
    checks++; if (bus.sched_error !== 1'b0 || bus.sched_busy !== 1'b1) begin errors++; $display("[TB] FAIL to_early got err=%b busy=%b expected err=0 busy=1", bus.sched_error, bus.sched_busy); end
    cyc(1);
    checks++; if (bus.sched_error !== 1'b1 || bus.sched_busy !== 1'b0) begin errors++; $display("[TB] FAIL to_expire got err=%b busy=%b expected err=1 busy=0", bus.sched_error, bus.sched_busy); end
    d0 = doneCnt;
    pulseStart(0, 0);
    cyc(3);
    checks++; if (bus.sched_error !== 1'b1 || doneCnt - d0 != 0) begin errors++; $display("[TB] FAIL to_start_ignored got err=%b done=%0d expected err=1 done=0", bus.sched_error, doneCnt - d0); end
    pulseAbort();
    checks++; if (bus.sched_error !== 1'b0 || bus.sched_busy !== 1'b0) begin errors++; $display("[TB] FAIL to_abort got err=%b busy=%b expected err=0 busy=0", bus.sched_error, bus.sched_busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulseStart(1, 1);
    waitStart(10, ok);
    cyc(3);
    checks++; if (!ok || bus.core_mode !== 1'b1 || bus.sched_busy !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre got ok=%0d mode=%b busy=%b expected 1 1 1", ok, bus.core_mode, bus.sched_busy); end
    rst = 1'b1;
    #1;
    checks++; if ({bus.core_start, bus.core_mode, bus.sched_busy, bus.sched_done, bus.sched_error} !== 5'b0) begin errors++; $display("[TB] FAIL rmid_flags got %b expected 00000", {bus.core_start, bus.core_mode, bus.sched_busy, bus.sched_done, bus.sched_error}); end
    @(negedge clk);
    rst = 1'b0;
    cyc(3);
    checks++; if (bus.sched_busy !== 1'b0 || bus.core_start !== 1'b0) begin errors++; $display("[TB] FAIL rmid_idle got busy=%b start=%b expected 0 0", bus.sched_busy, bus.core_start); end
  endtask

  initial begin
    rst               = 1'b1;
    bus.cmd_start     = 1'b0;
    bus.cmd_abort     = 1'b0;
    bus.cfg_num_steps = '0;
    bus.cfg_n_critic  = '0;
    test_reset();
    test_critic_schedule();
    cyc(3);
    test_no_critic();
    cyc(3);
    test_zero_steps();
    cyc(3);
    test_latency();
    cyc(3);
    test_back_to_back();
    cyc(3);
    test_abort();
    cyc(3);
    test_timeout();
    cyc(3);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
